dm_cache_ctrl: RTL and testbench

- Miss-handling controller for the direct-mapped write-back data cache.
- Sits between the CPU memory stage and the backing RAM. Holds the tag/valid/dirty/data line array.
- Performs the lookup and, on a miss, writes back a dirty victim and then refills from RAM over a req/ack handshake.
- Policy: write-allocate, write-back. Each line holds one word.

---
 rtl/dm_cache_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-allocate, write-back data cache controller.
// Holds the line array and resolves misses with an optional victim write-back
// followed by a refill, both over a registered req/ack RAM handshake.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_e;

  state_e              state_q;

  // Latched CPU request
  logic                req_we_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;

  // Set by a completed refill so the following lookup is not counted as a hit
  logic                retry_q;

  // Line array; only valid/dirty need a defined reset value
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  // Registered outputs
  logic                busy_q;
  logic                cpu_done_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]    hit_count_q;
  logic [CNT_W-1:0]    miss_count_q;

  // Decoded request fields and the tag compare for the addressed line
  logic [IDX_W-1:0]    req_idx_c;
  logic [TAG_W-1:0]    req_tag_c;
  logic                hit_c;
  logic                victim_dirty_c;
  logic [CNT_W-1:0]    hit_inc_c;
  logic [CNT_W-1:0]    miss_inc_c;

  // Lookup decode and saturating counter increments
  always_comb begin
    req_idx_c      = req_addr_q[IDX_W-1:0];
    req_tag_c      = req_addr_q[ADDR_W-1:IDX_W];
    hit_c          = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
    victim_dirty_c = valid_q[req_idx_c] && dirty_q[req_idx_c];
    hit_inc_c      = (hit_count_q == '1)  ? hit_count_q  : hit_count_q  + CNT_W'(1);
    miss_inc_c     = (miss_count_q == '1) ? miss_count_q : miss_count_q + CNT_W'(1);
  end

  // Controller FSM, line array updates and all registered outputs
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      retry_q      <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      busy_q       <= 1'b0;
      cpu_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      cpu_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            req_we_q    <= cpu_we;
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
            retry_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit_c) begin
            if (req_we_q) begin
              data_q[req_idx_c]  <= req_wdata_q;
              dirty_q[req_idx_c] <= 1'b1;
            end else begin
              cpu_rdata_q <= data_q[req_idx_c];
            end
            if (!retry_q) begin
              hit_count_q <= hit_inc_c;
            end
            retry_q    <= 1'b0;
            cpu_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            miss_count_q <= miss_inc_c;
            mem_req_q    <= 1'b1;
            if (victim_dirty_c) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx_c], req_idx_c};
              mem_wdata_q <= data_q[req_idx_c];
              state_q     <= WRITEBACK;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= req_addr_q;
              state_q     <= REFILL;
            end
          end
        end

        WRITEBACK: begin
          // Drop req for one cycle before the refill request goes out
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= REFILL;
          end
        end

        REFILL: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= req_addr_q;
          end else if (mem_ack) begin
            data_q[req_idx_c]  <= mem_rdata;
            tag_q[req_idx_c]   <= req_tag_c;
            valid_q[req_idx_c] <= 1'b1;
            dirty_q[req_idx_c] <= 1'b0;
            mem_req_q          <= 1'b0;
            retry_q            <= 1'b1;
            state_q            <= LOOKUP;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_busy   = busy_q;
  assign cpu_done   = cpu_done_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: transaction-level cache model with a per-cycle
// expected-output timeline derived from the documented latencies.
module tb_dm_cache_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_busy, cpu_done;
  logic [7:0] cpu_rdata;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dm_cache_ctrl #(.ADDR_W(8), .DATA_W(8), .IDX_W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Expected outputs for the current cycle
  logic       exp_busy, exp_done, exp_req, exp_we, exp_mzero;
  logic [7:0] exp_addr, exp_wdata, exp_rdata;
  int         m_hit, m_miss;

  // Cache contents model
  logic       m_valid [16];
  logic       m_dirty [16];
  logic [3:0] m_tag   [16];
  logic [7:0] m_data  [16];

  // Observed write-back traffic, used to pin a few literal expectations
  int         wb_cycles = 0;
  logic [7:0] seen_wb_addr = 8'h00;
  logic [7:0] seen_wb_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Compare process: DUT outputs against the model on every cycle
  always @(negedge clk) begin
    if (check_en) begin
      chk("cpu_busy",   32'(cpu_busy),   32'(exp_busy));
      chk("cpu_done",   32'(cpu_done),   32'(exp_done));
      chk("cpu_rdata",  32'(cpu_rdata),  32'(exp_rdata));
      chk("mem_req",    32'(mem_req),    32'(exp_req));
      chk("hit_count",  32'(hit_count),  32'(m_hit));
      chk("miss_count", 32'(miss_count), 32'(m_miss));
      if (exp_req) begin
        chk("mem_we",   32'(mem_we),   32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      if (exp_mzero) begin
        chk("rst_mem_we",    32'(mem_we),    32'(0));
        chk("rst_mem_addr",  32'(mem_addr),  32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      end
    end
    if (mem_req === 1'b1 && mem_we === 1'b1) begin
      wb_cycles++;
      seen_wb_addr = mem_addr;
      seen_wb_data = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hit = 0; m_miss = 0;
    exp_rdata = 8'h00; exp_busy = 1'b0; exp_done = 1'b0;
    exp_req = 1'b0; exp_we = 1'b0; exp_mzero = 1'b1;
  endtask

  // CPU-side garbage while busy; none of it may be accepted
  task automatic noise();
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = 8'($urandom);
    cpu_wdata = 8'($urandom);
  endtask

  // RAM side: real ack on the last request cycle, random stray acks when no request is up
  task automatic drive_ack(input bit in_req, input bit last);
    mem_rdata = 8'($urandom);
    if (in_req) mem_ack = last;
    else        mem_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_tick();
    cpu_req = 1'b0;
    tick();
    exp_done = 1'b0;
    exp_busy = 1'b0;
    exp_req  = 1'b0;
    drive_ack(0, 0);
  endtask

  // One CPU transaction; called in an IDLE cycle, returns in its done cycle
  task automatic run_txn(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                         input int dw, input int dr, input logic [7:0] fillv, input int abort_at);
    logic [3:0] idx;
    logic [3:0] tag;
    bit         hit;
    idx = addr[3:0];
    tag = addr[7:4];
    exp_mzero = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    tick();
    noise(); drive_ack(0, 0);
    exp_busy = 1'b1; exp_done = 1'b0; exp_req = 1'b0;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    tick();
    if (!hit) begin
      m_miss = sat(m_miss);
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int i = 0; i <= dw; i++) begin
          noise();
          exp_req = 1'b1; exp_we = 1'b1;
          exp_addr = {m_tag[idx], idx}; exp_wdata = m_data[idx];
          drive_ack(1, i == dw);
          tick();
        end
        noise(); exp_req = 1'b0; drive_ack(0, 0);
        tick();
      end
      for (int i = 0; i <= dr; i++) begin
        noise();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = addr;
        drive_ack(1, i == dr);
        if (i == dr) mem_rdata = fillv;
        if (i == abort_at) begin
          clr = 1'b0; mem_ack = 1'b0;
          tick();
          model_reset();
          clr = 1'b1; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'($urandom);
          tick();
          mem_ack = 1'b0;
          return;
        end
        tick();
      end
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = fillv; m_dirty[idx] = 1'b0;
      noise(); exp_req = 1'b0; drive_ack(0, 0);
      tick();
    end else begin
      m_hit = sat(m_hit);
    end
    if (we) begin
      m_data[idx]  = wd;
      m_dirty[idx] = 1'b1;
    end else begin
      exp_rdata = m_data[idx];
    end
    cpu_req = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b1; exp_req = 1'b0;
    drive_ack(0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int         wb_before;
    clr = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    check_en = 1'b1;
    chk("rst_busy",  32'(cpu_busy),  32'(0));
    chk("rst_req",   32'(mem_req),   32'(0));
    chk("rst_rdata", 32'(cpu_rdata), 32'(0));
    idle_tick();

    // Clean read miss, ack 3 cycles after request
    run_txn(1'b0, 8'h35, 8'h00, 0, 3, 8'hA7, -1);
    chk("pin_rd_a7",  32'(cpu_rdata),  32'h0A7);
    chk("pin_miss1",  32'(miss_count), 32'(1));
    chk("pin_no_wb",  32'(wb_cycles),  32'(0));
    idle_tick();

    // Read hit
    run_txn(1'b0, 8'h35, 8'h00, 0, 0, 8'h00, -1);
    chk("pin_hit_rd", 32'(cpu_rdata), 32'h0A7);
    chk("pin_hit1",   32'(hit_count), 32'(1));

    // Write hit then conflicting read: dirty victim written back
    run_txn(1'b1, 8'h35, 8'h5C, 0, 0, 8'h00, -1);
    run_txn(1'b0, 8'h75, 8'h00, 2, 1, 8'h3E, -1);
    chk("pin_wb_addr",   32'(seen_wb_addr), 32'h035);
    chk("pin_wb_data",   32'(seen_wb_data), 32'h05C);
    chk("pin_wb_cycles", 32'(wb_cycles),    32'(3));
    chk("pin_rd_3e",     32'(cpu_rdata),    32'h03E);
    idle_tick();

    // Write miss allocates, then read hits the written data
    run_txn(1'b1, 8'h12, 8'h99, 0, 2, 8'h44, -1);
    run_txn(1'b0, 8'h12, 8'h00, 0, 0, 8'h00, -1);
    chk("pin_rd_99", 32'(cpu_rdata), 32'h099);

    // Refilled line is clean: evicting it needs no write-back
    wb_before = wb_cycles;
    run_txn(1'b0, 8'h35, 8'h00, 1, 0, 8'h5A, -1);
    chk("pin_clean_evict", 32'(wb_cycles - wb_before), 32'(0));
    idle_tick();

    // Reset during refill, then a late ack
    run_txn(1'b0, 8'h56, 8'h00, 0, 3, 8'h11, 1);
    chk("pin_abort_busy", 32'(cpu_busy),   32'(0));
    chk("pin_abort_req",  32'(mem_req),    32'(0));
    chk("pin_abort_miss", 32'(miss_count), 32'(0));
    idle_tick();
    run_txn(1'b0, 8'h35, 8'h00, 0, 1, 8'h22, -1);
    chk("pin_post_rst_miss", 32'(miss_count), 32'(1));
    chk("pin_post_rst_hit",  32'(hit_count),  32'(0));
    chk("pin_post_rst_rd",   32'(cpu_rdata),  32'h022);
    idle_tick();

    // Randomized traffic over a small conflicting address set
    for (int n = 0; n < 400; n++) begin
      a = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
      run_txn(1'($urandom_range(0, 1)), a, 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 8'($urandom), -1);
      repeat (int'($urandom_range(0, 2))) idle_tick();
    end

    // Hit counter saturation on a resident line
    run_txn(1'b0, 8'hC7, 8'h00, 0, 0, 8'h6D, -1);
    chk("pin_rd_6d", 32'(cpu_rdata), 32'h06D);
    for (int n = 0; n < 300; n++) begin
      run_txn(1'($urandom_range(0, 1)), 8'hC7, 8'($urandom), 0, 0, 8'h00, -1);
    end
    chk("pin_hit_sat", 32'(hit_count), 32'(255));
    idle_tick();
    idle_tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
